// File: rtl/reg_bank.sv
// -----------------------------------------------------------------------------
// reg_bank
//
// Purpose:
//   Multi-entry register bank of soc_pkg::data_t words. Writes complete in a
//   single cycle. Reads use a valid/ready request/response handshake: an
//   accepted request is answered in the following cycle. The response is held
//   in a one-entry output stage until the consumer takes it.
//
// Ports:
//   clk           rising-edge clock
//   rst_n         synchronous active-low reset
//   wr_en         write strobe
//   wr_addr       write address (ADDR_W)
//   wr_data       write data (data_t)
//   wr_err        one-cycle pulse after a write to an address >= NUM_REGS
//   rd_req_valid  read request valid
//   rd_req_ready  read request ready (request accepted when valid && ready)
//   rd_addr       read address, sampled when the request is accepted
//   rd_rsp_valid  response valid
//   rd_rsp_ready  consumer ready for the response
//   rd_data       response data (data_t), zero for out-of-range reads
//   rd_err        response flag for out-of-range reads, qualified by rd_rsp_valid
//
// Optional feature (macro REG_BANK_STATS_EN):
//   wr_count      16-bit saturating count of in-range writes
//   rd_count      16-bit saturating count of response handshakes
// -----------------------------------------------------------------------------

package soc_pkg;
    localparam int DATA_WIDTH = 32;
    typedef logic [DATA_WIDTH-1:0] data_t;
endpackage

module reg_bank
    import soc_pkg::*;
#(
    parameter int    NUM_REGS  = 8,
    parameter int    ADDR_W    = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1,
    parameter data_t RESET_VAL = '0
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  data_t             wr_data,
    output logic              wr_err,

    input  logic              rd_req_valid,
    output logic              rd_req_ready,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              rd_rsp_valid,
    input  logic              rd_rsp_ready,
    output data_t             rd_data,
    output logic              rd_err
`ifdef REG_BANK_STATS_EN
    ,
    output logic [15:0]       wr_count,
    output logic [15:0]       rd_count
`endif
);

    typedef enum logic {
        IDLE,
        RESP
    } rsp_state_t;

    // One extra bit so NUM_REGS itself is representable when it is a power
    // of two (e.g. NUM_REGS=8 with ADDR_W=3).
    localparam logic [ADDR_W:0] NUM_REGS_W = (ADDR_W + 1)'(NUM_REGS);

    data_t      mem [NUM_REGS];
    rsp_state_t state;
    rsp_state_t state_next;

    logic  wr_in_range;
    logic  rd_in_range;
    logic  req_fire;
    logic  rsp_fire;
    logic  load_rsp;
    data_t rd_word;

    assign wr_in_range = ({1'b0, wr_addr} < NUM_REGS_W);
    assign rd_in_range = ({1'b0, rd_addr} < NUM_REGS_W);

    assign rd_rsp_valid = (state == RESP);
    assign rd_req_ready = !rd_rsp_valid || rd_rsp_ready;
    assign req_fire     = rd_req_valid && rd_req_ready;
    assign rsp_fire     = rd_rsp_valid && rd_rsp_ready;

    // Storage. Addresses in NUM_REGS..2^ADDR_W-1 never match any entry, so
    // out-of-range writes leave every entry untouched.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_REGS; i++) begin
            if (!rst_n) begin
                mem[i] <= RESET_VAL;
            end else if (wr_en && (wr_addr == ADDR_W'(i))) begin
                mem[i] <= wr_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_err <= 1'b0;
        end else begin
            wr_err <= wr_en && !wr_in_range;
        end
    end

    // Word presented to the output stage on accept. A same-edge write to the
    // same in-range address is forwarded so the response sees the new data.
    always_comb begin
        rd_word = '0;
        if (rd_in_range) begin
            if (wr_en && (wr_addr == rd_addr)) begin
                rd_word = wr_data;
            end else begin
                rd_word = mem[rd_addr];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // In RESP the request side is only ready when the consumer is, so an
    // accept there always coincides with a response fire and the stage is
    // refilled back-to-back.
    always_comb begin
        state_next = state;
        load_rsp   = 1'b0;
        case (state)
            IDLE: begin
                if (req_fire) begin
                    state_next = RESP;
                    load_rsp   = 1'b1;
                end
            end
            RESP: begin
                if (req_fire) begin
                    state_next = RESP;
                    load_rsp   = 1'b1;
                end else if (rsp_fire) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Output hold stage: only reloaded on accept, so writes to the address
    // of a held response do not disturb it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_data <= '0;
            rd_err  <= 1'b0;
        end else if (load_rsp) begin
            rd_data <= rd_word;
            rd_err  <= !rd_in_range;
        end
    end

`ifdef REG_BANK_STATS_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_count <= '0;
            rd_count <= '0;
        end else begin
            if (wr_en && wr_in_range && (wr_count != 16'hFFFF)) begin
                wr_count <= wr_count + 16'd1;
            end
            if (rsp_fire && (rd_count != 16'hFFFF)) begin
                rd_count <= rd_count + 16'd1;
            end
        end
    end
`endif

    // A stalled response must not change until it is consumed.
    property p_hold_stable;
        @(posedge clk) disable iff (!rst_n)
            (rd_rsp_valid && !rd_rsp_ready) |=>
                (rd_rsp_valid && $stable(rd_data) && $stable(rd_err));
    endproperty
    a_hold_stable: assert property (p_hold_stable);

    // Error responses always carry zero data.
    property p_err_zero;
        @(posedge clk) disable iff (!rst_n)
            (rd_rsp_valid && rd_err) |-> (rd_data == '0);
    endproperty
    a_err_zero: assert property (p_err_zero);

endmodule

// File: tb/tb_reg_bank.sv
// -----------------------------------------------------------------------------
// tb_reg_bank
//
// Self-checking bench for reg_bank with NUM_REGS=6 (ADDR_W=3) so addresses
// 6 and 7 are out of range. A reference model (array + pending-response flag)
// tracks the expected outputs every cycle; directed sections also check
// literal values. Build with +define+REG_BANK_STATS_EN to cover the counters.
// -----------------------------------------------------------------------------

module tb_reg_bank;
    import soc_pkg::*;

    localparam int    NUM_REGS  = 6;
    localparam int    ADDR_W    = 3;
    localparam data_t RESET_VAL = 32'h0000_5A5A;

    logic tb_clk = 1'b0;
    always #5 tb_clk = ~tb_clk;

    logic              rst_n;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    data_t             wr_data;
    logic              wr_err;
    logic              rd_req_valid;
    logic              rd_req_ready;
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_rsp_valid;
    logic              rd_rsp_ready;
    data_t             rd_data;
    logic              rd_err;
`ifdef REG_BANK_STATS_EN
    logic [15:0]       wr_count;
    logic [15:0]       rd_count;
`endif

    reg_bank #(
        .NUM_REGS  (NUM_REGS),
        .ADDR_W    (ADDR_W),
        .RESET_VAL (RESET_VAL)
    ) dut (
        .clk          (tb_clk),
        .rst_n        (rst_n),
        .wr_en        (wr_en),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .wr_err       (wr_err),
        .rd_req_valid (rd_req_valid),
        .rd_req_ready (rd_req_ready),
        .rd_addr      (rd_addr),
        .rd_rsp_valid (rd_rsp_valid),
        .rd_rsp_ready (rd_rsp_ready),
        .rd_data      (rd_data),
        .rd_err       (rd_err)
`ifdef REG_BANK_STATS_EN
        ,
        .wr_count     (wr_count),
        .rd_count     (rd_count)
`endif
    );

    int num_checks = 0;
    int num_errors = 0;

    // Reference model: storage contents plus the one pending response.
    data_t model_mem [NUM_REGS];
    bit    m_valid;
    data_t m_data;
    bit    m_err;
    bit    m_wr_err;
    int    m_wr_count;
    int    m_rd_count;

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        num_checks++;
        if (actual !== expected) begin
            num_errors++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
        end
    endtask

    task automatic modelReset();
        for (int i = 0; i < NUM_REGS; i++) model_mem[i] = RESET_VAL;
        m_valid    = 1'b0;
        m_data     = '0;
        m_err      = 1'b0;
        m_wr_err   = 1'b0;
        m_wr_count = 0;
        m_rd_count = 0;
    endtask

    // Advance the model across one clock edge: the write lands first, so a
    // read of the same address on that edge observes the new value.
    task automatic modelStep(input bit we, input logic [ADDR_W-1:0] wa,
                             input data_t wd, input bit rv,
                             input logic [ADDR_W-1:0] ra, input bit rr);
        bit req_ready;
        bit req_fire;
        bit rsp_fire;
        rsp_fire  = m_valid && rr;
        req_ready = !m_valid || rr;
        req_fire  = rv && req_ready;
        if (rsp_fire && m_rd_count < 65535) m_rd_count++;
        m_wr_err = we && (int'(wa) >= NUM_REGS);
        if (we && int'(wa) < NUM_REGS) begin
            model_mem[int'(wa)] = wd;
            if (m_wr_count < 65535) m_wr_count++;
        end
        if (req_fire) begin
            m_valid = 1'b1;
            m_err   = (int'(ra) >= NUM_REGS);
            m_data  = m_err ? '0 : model_mem[int'(ra)];
        end else if (rsp_fire) begin
            m_valid = 1'b0;
        end
    endtask

    task automatic checkModel();
        checkOutput("rd_rsp_valid", 32'(rd_rsp_valid), 32'(m_valid));
        checkOutput("rd_req_ready", 32'(rd_req_ready), 32'(!m_valid || rd_rsp_ready));
        checkOutput("wr_err", 32'(wr_err), 32'(m_wr_err));
        if (m_valid) begin
            checkOutput("rd_data", rd_data, m_data);
            checkOutput("rd_err", 32'(rd_err), 32'(m_err));
        end
`ifdef REG_BANK_STATS_EN
        checkOutput("wr_count", 32'(wr_count), 32'(m_wr_count));
        checkOutput("rd_count", 32'(rd_count), 32'(m_rd_count));
`endif
    endtask

    // Drive one cycle of inputs (called at a negedge), check the DUT against
    // the model before the edge, then advance the model and return at the
    // next negedge.
    task automatic applyStimulus(input bit we, input logic [ADDR_W-1:0] wa,
                                 input data_t wd, input bit rv,
                                 input logic [ADDR_W-1:0] ra, input bit rr);
        wr_en        = we;
        wr_addr      = wa;
        wr_data      = wd;
        rd_req_valid = rv;
        rd_addr      = ra;
        rd_rsp_ready = rr;
        #1;
        checkModel();
        @(posedge tb_clk);
        modelStep(we, wa, wd, rv, ra, rr);
        @(negedge tb_clk);
    endtask

    task automatic doReset(input int cycles);
        rst_n        = 1'b0;
        wr_en        = 1'b0;
        rd_req_valid = 1'b0;
        rd_rsp_ready = 1'b0;
        repeat (cycles) begin
            @(posedge tb_clk);
            modelReset();
            @(negedge tb_clk);
            checkOutput("reset_rsp_valid", 32'(rd_rsp_valid), 32'd0);
            checkOutput("reset_wr_err", 32'(wr_err), 32'd0);
            checkOutput("reset_rd_data", rd_data, 32'd0);
        end
        rst_n = 1'b1;
    endtask

    task automatic idleCycle();
        applyStimulus(1'b0, '0, '0, 1'b0, '0, 1'b1);
    endtask

    initial begin
        int resp_seen;
        int rc0;
        rst_n        = 1'b0;
        wr_en        = 1'b0;
        wr_addr      = '0;
        wr_data      = '0;
        rd_req_valid = 1'b0;
        rd_addr      = '0;
        rd_rsp_ready = 1'b0;
        modelReset();

        doReset(2);

        // Reset restores every entry.
        applyStimulus(1'b1, 3'd3, 32'h0000_0077, 1'b0, '0, 1'b1);
        doReset(2);
        for (int a = 0; a < NUM_REGS; a++) begin
            applyStimulus(1'b0, '0, '0, 1'b1, ADDR_W'(a), 1'b1);
            checkOutput("reset_entry", rd_data, RESET_VAL);
        end
        idleCycle();

        // Plain write then read.
        applyStimulus(1'b1, 3'd2, 32'h0000_00A5, 1'b0, '0, 1'b1);
        applyStimulus(1'b0, '0, '0, 1'b1, 3'd2, 1'b1);
        checkOutput("wr_rd_valid", 32'(rd_rsp_valid), 32'd1);
        checkOutput("wr_rd_data", rd_data, 32'h0000_00A5);
        checkOutput("wr_rd_err", 32'(rd_err), 32'd0);
        idleCycle();

        // Write-first bypass on the same edge.
        applyStimulus(1'b1, 3'd5, 32'h0000_003C, 1'b1, 3'd5, 1'b1);
        checkOutput("bypass_data", rd_data, 32'h0000_003C);
        idleCycle();

        // Backpressure: held response survives writes to its address.
        applyStimulus(1'b1, 3'd1, 32'h0000_0011, 1'b0, '0, 1'b1);
        applyStimulus(1'b0, '0, '0, 1'b1, 3'd1, 1'b0);
        for (int k = 0; k < 4; k++) begin
            applyStimulus(1'b1, 3'd1, 32'h0000_0022, 1'b1, 3'd4, 1'b0);
            checkOutput("hold_data", rd_data, 32'h0000_0011);
            checkOutput("hold_req_ready", 32'(rd_req_ready), 32'd0);
        end
        applyStimulus(1'b0, '0, '0, 1'b0, '0, 1'b1);
        applyStimulus(1'b0, '0, '0, 1'b1, 3'd1, 1'b1);
        checkOutput("after_hold_data", rd_data, 32'h0000_0022);
        idleCycle();

        // Out-of-range write and read.
        applyStimulus(1'b1, 3'd7, 32'hDEAD_BEEF, 1'b0, '0, 1'b1);
        checkOutput("oor_wr_err_pulse", 32'(wr_err), 32'd1);
        idleCycle();
        checkOutput("oor_wr_err_clear", 32'(wr_err), 32'd0);
        for (int a = 0; a < NUM_REGS; a++) begin
            applyStimulus(1'b0, '0, '0, 1'b1, ADDR_W'(a), 1'b1);
        end
        applyStimulus(1'b0, '0, '0, 1'b1, 3'd6, 1'b1);
        checkOutput("oor_rd_data", rd_data, 32'd0);
        checkOutput("oor_rd_err", 32'(rd_err), 32'd1);
        idleCycle();

        // Reset in the middle of a stalled response drops it.
        applyStimulus(1'b0, '0, '0, 1'b1, 3'd2, 1'b0);
        doReset(1);
        idleCycle();

        // Streaming: one read per cycle with random writes alongside.
        rc0       = m_rd_count;
        resp_seen = 0;
        for (int k = 0; k < 100; k++) begin
            applyStimulus(1'($urandom_range(0, 1)), ADDR_W'($urandom_range(0, 7)),
                          data_t'($urandom), 1'b1, ADDR_W'($urandom_range(0, 7)), 1'b1);
            if (rd_rsp_valid === 1'b1) resp_seen++;
        end
        idleCycle();
        checkOutput("stream_resp_count", 32'(resp_seen), 32'd100);
`ifdef REG_BANK_STATS_EN
        checkOutput("stream_rd_count", 32'(rd_count), 32'(rc0 + 100));
`else
        checkOutput("stream_model_count", 32'(m_rd_count - rc0), 32'(resp_seen));
`endif

        // Fully random traffic including consumer stalls.
        for (int k = 0; k < 300; k++) begin
            applyStimulus(1'($urandom_range(0, 1)), ADDR_W'($urandom_range(0, 7)),
                          data_t'($urandom), 1'($urandom_range(0, 1)),
                          ADDR_W'($urandom_range(0, 7)), ($urandom_range(0, 3) != 0));
        end
        idleCycle();
        idleCycle();

        $display("Simulation finished: %0d checks, %0d errors", num_checks, num_errors);
        $finish;
    end

endmodule
